cu_sequencer: RTL and testbench
===============================

CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 data_bus_in  in  8  opcode byte from memory; sampled at the end of FETCH and CB_FETCH cycles.
REQ-004 flag_z  in  1  current Z flag; used for conditional-end evaluation.
REQ-005 flag_c  in  1  current C flag; used for conditional-end evaluation.
REQ-006 stall  in  1  memory not ready; freezes the sequencer.
REQ-007 irq_pending  in  1  interrupt pending; wakes the sequencer from HALT.
REQ-008 control_signals  out  65  microcode control word consumed by the downstream field mapper; bit layout matches the mapper's field map (cu_adv_sel = bits 31:30).
REQ-009 cu_state  out  3  current state encoding.
REQ-010 micro_step  out  4  current micro-step index.
REQ-011 opcode  out  8  latched opcode.
REQ-012 cb_mode  out  1  high while a CB-prefixed opcode is executing.
REQ-013 inst_done  out  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-014 The states SHALL be FETCH, CB_FETCH, EXEC and HALT.
REQ-015 In FETCH the block SHALL drive FETCH_WORD: db_nread=0, write_inst_buffer=1, PC increment selected. On the clock edge it SHALL latch data_bus_in into opcode, clear cb_mode, set step=0 and move to EXEC.
REQ-016 In EXEC control_signals SHALL equal ROM[{cb_mode, opcode, micro_step}], combinationally, with zero-cycle latency from state.
REQ-017 The block SHALL decode adv = control_signals[31:30] of the current word:
- 00: step+1, stay in EXEC.
- 01: end of instruction; pulse inst_done and go to FETCH.
- 10: conditional end; the condition is opcode[4:3] (00=NZ, 01=Z, 10=NC, 11=C). If the condition is false, end as for 01; if true, step+1.
- 11: CB prefix; go to CB_FETCH.
REQ-018 CB_FETCH SHALL drive FETCH_WORD. On the clock edge it SHALL latch data_bus_in into opcode, set cb_mode=1, set step=0 and move to EXEC.
REQ-019 In EXEC with cb_mode=1, adv=11 SHALL be treated as 01 (no double prefix).
REQ-020 Opcode 0x76 with cb_mode=0, on its end-of-instruction step, SHALL move to HALT instead of FETCH; inst_done still pulses.
REQ-021 HALT SHALL drive IDLE_WORD (all write enables 0, db_nread=1, db_nwrite=1). It SHALL stay in HALT until irq_pending=1, then go to FETCH on the next edge.
REQ-022 While stall=1, state, step, opcode and cb_mode SHALL hold; control_signals SHALL be IDLE_WORD; inst_done SHALL be 0.
- stall has priority over every transition, including HALT wake-up.
REQ-023 Step overflow: if step=15 and adv=00, the sequencer SHALL end the instruction as for 01. The step SHALL never wrap to 0 within an instruction.
REQ-024 irq_pending SHALL be ignored outside HALT.
REQ-025 cu_state, micro_step, opcode and cb_mode SHALL be direct register outputs.

Reset
REQ-026 rst=1 SHALL immediately force: state=FETCH, micro_step=0, opcode=0x00, cb_mode=0, inst_done=0, control_signals=IDLE_WORD.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction. No partial inst_done SHALL be produced.
REQ-028 On the first clock edge after rst deasserts, the block SHALL be in FETCH driving FETCH_WORD.

Structure
REQ-029 A shared package cu_pkg SHALL hold:
- state encoding constants;
- adv_sel codes;
- the FETCH_WORD and IDLE_WORD constants;
- the condition-code encoding;
- the opcode constant HALT_OP=0x76.
REQ-030 The microcode table SHALL be a separate combinational sub-module cu_microcode_rom (address 13 bits = cb_mode, opcode, step; data 65 bits). The sequencer SHALL contain only state, counters and muxing.

Verification
REQ-031 Reset then idle: rst pulse -> control_signals=IDLE_WORD during reset; FETCH_WORD on the first cycle after release; micro_step=0.
REQ-032 NOP: data_bus_in=0x00 in FETCH, ROM step0 adv=01 -> EXEC one cycle; inst_done pulses once; back to FETCH; 2 cycles total.
REQ-033 Conditional JP NZ (0xC2) with flag_z=1 at the adv=10 step -> ends at that step. With flag_z=0 -> continues to the following steps.
REQ-034 CB prefix: 0xCB then 0x37 -> CB_FETCH entered; cb_mode=1; opcode=0x37; ROM rows from the CB half; cb_mode cleared at the next FETCH.
REQ-035 HALT and stall:
- 0x76 -> HALT with IDLE_WORD; irq_pending=1 with stall=1 -> remains in HALT.
- stall=0 -> FETCH on the next edge.
- Separately, stall mid-EXEC for 3 cycles -> micro_step frozen, no inst_done.
REQ-036 Overflow and async reset:
- ROM row with adv=00 through step 15 -> forced end at step 15; inst_done pulses.
- rst asserted at step 4 -> asynchronous return to FETCH state values without waiting for a clock edge.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared constants and control-word layout for the control-unit sequencer and its microcode ROM.
package cu_pkg;

  localparam int unsigned CTRL_W  = 65;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ROM_AW  = 1 + OP_W + STEP_W;
  localparam int unsigned RSVD_W  = 20;
  localparam int unsigned WREN_W  = 25;

  // Sequencer state encoding
  localparam logic [STATE_W-1:0] ST_FETCH    = 3'd0;
  localparam logic [STATE_W-1:0] ST_CB_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC     = 3'd2;
  localparam logic [STATE_W-1:0] ST_HALT     = 3'd3;

  // Micro-step advance selector (control word bits 31:30)
  localparam logic [1:0] ADV_NEXT = 2'b00;
  localparam logic [1:0] ADV_END  = 2'b01;
  localparam logic [1:0] ADV_COND = 2'b10;
  localparam logic [1:0] ADV_CB   = 2'b11;

  // Condition codes carried in opcode[4:3]
  localparam logic [1:0] CC_NZ = 2'b00;
  localparam logic [1:0] CC_Z  = 2'b01;
  localparam logic [1:0] CC_NC = 2'b10;
  localparam logic [1:0] CC_C  = 2'b11;

  localparam logic [OP_W-1:0]   HALT_OP  = 8'h76;
  localparam logic [OP_W-1:0]   CB_OP    = 8'hCB;
  localparam logic [STEP_W-1:0] STEP_MAX = 4'd15;
  localparam logic [1:0]        PC_HOLD  = 2'b00;
  localparam logic [1:0]        PC_INC   = 2'b01;

  // Control word as seen by the downstream field mapper (MSB first)
  typedef struct packed {
    logic [RSVD_W-1:0] rsvd;
    logic [ROM_AW-1:0] trace;
    logic [1:0]        adv_sel;
    logic [WREN_W-1:0] wr_en;
    logic [1:0]        pc_sel;
    logic              wr_inst_buf;
    logic              db_nwrite;
    logic              db_nread;
  } ctrl_word_t;

  localparam ctrl_word_t IDLE_WORD = '{
    rsvd: '0, trace: '0, adv_sel: ADV_NEXT, wr_en: '0,
    pc_sel: PC_HOLD, wr_inst_buf: 1'b0, db_nwrite: 1'b1, db_nread: 1'b1
  };

  localparam ctrl_word_t FETCH_WORD = '{
    rsvd: '0, trace: '0, adv_sel: ADV_NEXT, wr_en: '0,
    pc_sel: PC_INC, wr_inst_buf: 1'b1, db_nwrite: 1'b1, db_nread: 1'b0
  };

  // True when the branch condition encoded in cc holds for the given flags
  function automatic logic cond_true(input logic [1:0] cc, input logic z, input logic c);
    logic r;
    case (cc)
      CC_NZ:   r = ~z;
      CC_Z:    r = z;
      CC_NC:   r = ~c;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cu_microcode_rom.sv
// Combinational microcode table indexed by {cb_mode, opcode, step}.
module cu_microcode_rom
  import cu_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output ctrl_word_t        data
);

  logic              cb;
  logic [OP_W-1:0]   op;
  logic [STEP_W-1:0] step;
  logic [1:0]        adv;

  assign {cb, op, step} = addr;

  // Sequencing field per row; unlisted opcodes behave as single-step no-ops
  always_comb begin
    adv = ADV_END;
    if (!cb) begin
      case (op)
        8'h01: adv = (step == 4'd3) ? ADV_END : ADV_NEXT;
        8'hC2: begin
          case (step)
            4'd0:    adv = ADV_NEXT;
            4'd1:    adv = ADV_COND;
            4'd2:    adv = ADV_NEXT;
            default: adv = ADV_END;
          endcase
        end
        CB_OP:   adv = ADV_CB;
        8'hD3:   adv = ADV_NEXT;
        default: adv = ADV_END;
      endcase
    end else begin
      case (op)
        CB_OP:   adv = ADV_CB;
        default: adv = (step == 4'd0) ? ADV_NEXT : ADV_END;
      endcase
    end
  end

  // Assemble the row; bus strobes are idle during execute steps
  always_comb begin
    data             = IDLE_WORD;
    data.trace       = addr;
    data.adv_sel     = adv;
  end

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: fetch / CB-fetch / execute / halt with microcode step counter.
module cu_sequencer
  import cu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     data_bus_in,
  input  logic                flag_z,
  input  logic                flag_c,
  input  logic                stall,
  input  logic                irq_pending,
  output logic [CTRL_W-1:0]   control_signals,
  output logic [STATE_W-1:0]  cu_state,
  output logic [STEP_W-1:0]   micro_step,
  output logic [OP_W-1:0]     opcode,
  output logic                cb_mode,
  output logic                inst_done
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic               cb_mode_q, cb_mode_d;
  ctrl_word_t         rom_word;
  ctrl_word_t         ctrl_c;
  logic               done_c;
  logic               end_c;
  logic               advance_c;

  cu_microcode_rom u_rom (
    .addr (ROM_AW'({cb_mode_q, opcode_q, step_q})),
    .data (rom_word)
  );

  // State, step, opcode and prefix registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      step_q    <= '0;
      opcode_q  <= '0;
      cb_mode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      opcode_q  <= opcode_d;
      cb_mode_q <= cb_mode_d;
    end
  end

  // Next-state, control-word mux and end-of-instruction decode; stall freezes everything
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    opcode_d  = opcode_q;
    cb_mode_d = cb_mode_q;
    ctrl_c    = IDLE_WORD;
    done_c    = 1'b0;
    end_c     = 1'b0;
    advance_c = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_FETCH, ST_CB_FETCH: begin
          ctrl_c    = FETCH_WORD;
          opcode_d  = data_bus_in;
          cb_mode_d = (state_q == ST_CB_FETCH);
          step_d    = '0;
          state_d   = ST_EXEC;
        end
        ST_EXEC: begin
          ctrl_c = rom_word;
          case (rom_word.adv_sel)
            ADV_NEXT: advance_c = 1'b1;
            ADV_END:  end_c = 1'b1;
            ADV_COND: begin
              if (cond_true(opcode_q[4:3], flag_z, flag_c)) advance_c = 1'b1;
              else                                          end_c     = 1'b1;
            end
            default: begin
              // A second prefix inside a CB opcode simply ends it
              if (cb_mode_q) begin
                end_c = 1'b1;
              end else begin
                state_d = ST_CB_FETCH;
                step_d  = '0;
              end
            end
          endcase
          // Last step saturates into an end rather than wrapping
          if (advance_c) begin
            if (step_q == STEP_MAX) end_c  = 1'b1;
            else                    step_d = step_q + 4'd1;
          end
          if (end_c) begin
            done_c  = 1'b1;
            step_d  = '0;
            state_d = (!cb_mode_q && opcode_q == HALT_OP) ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          if (irq_pending) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Reset overrides the combinational outputs immediately
  assign control_signals = rst ? CTRL_W'(IDLE_WORD) : CTRL_W'(ctrl_c);
  assign inst_done       = done_c & ~rst;
  assign cu_state        = state_q;
  assign micro_step      = step_q;
  assign opcode          = opcode_q;
  assign cb_mode         = cb_mode_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: reset, NOP, conditional end, CB prefix, HALT, stall, overflow, async reset.
module tb_cu_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  data_bus_in;
  logic        flag_z;
  logic        flag_c;
  logic        stall;
  logic        irq_pending;
  logic [64:0] control_signals;
  logic [2:0]  cu_state;
  logic [3:0]  micro_step;
  logic [7:0]  opcode;
  logic        cb_mode;
  logic        inst_done;

  int vectors = 0;
  int miscompares = 0;

  // Hand-defined expected word forms
  localparam logic [64:0] IDLE_W  = 65'h3;
  localparam logic [64:0] FETCH_W = 65'hE;

  logic [16:0] obs;
  logic [16:0] exp_o;
  logic [64:0] exp_w;

  assign obs = {cu_state, micro_step, opcode, cb_mode, inst_done};

  cu_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .data_bus_in     (data_bus_in),
    .flag_z          (flag_z),
    .flag_c          (flag_c),
    .stall           (stall),
    .irq_pending     (irq_pending),
    .control_signals (control_signals),
    .cu_state        (cu_state),
    .micro_step      (micro_step),
    .opcode          (opcode),
    .cb_mode         (cb_mode),
    .inst_done       (inst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected EXEC row: trace field {cb, op, step}, selector, idle strobes
  function automatic logic [64:0] mk_word(input logic cb, input logic [7:0] op,
                                          input logic [3:0] st, input logic [1:0] adv);
    return {20'd0, cb, op, st, adv, 25'd0, 5'b00011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; data_bus_in = 8'h00; flag_z = 1'b0; flag_c = 1'b0; stall = 1'b0; irq_pending = 1'b0;
    #1 rst = 1'b1;
    #1;
    exp_o = {3'd0, 4'd0, 8'h00, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL reset_regs: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== IDLE_W) begin miscompares++; $display("FAIL reset_ctrl: got %h want %h", control_signals, IDLE_W); end
    tick(); tick();
    vectors++; if (control_signals !== IDLE_W) begin miscompares++; $display("FAIL reset_held_ctrl: got %h want %h", control_signals, IDLE_W); end
    rst = 1'b0;
    #1;
    vectors++; if (control_signals !== FETCH_W) begin miscompares++; $display("FAIL release_ctrl: got %h want %h", control_signals, FETCH_W); end
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL release_regs: got %h want %h", obs, exp_o); end
  endtask

  task automatic test_nop();
    data_bus_in = 8'h00;
    tick();
    exp_o = {3'd2, 4'd0, 8'h00, 1'b0, 1'b1}; exp_w = mk_word(1'b0, 8'h00, 4'd0, 2'b01);
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL nop_exec: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL nop_word: got %h want %h", control_signals, exp_w); end
    tick();
    exp_o = {3'd0, 4'd0, 8'h00, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL nop_refetch: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== FETCH_W) begin miscompares++; $display("FAIL nop_fetch_word: got %h want %h", control_signals, FETCH_W); end
  endtask

  task automatic test_jp_nz();
    logic [16:0] taken [5];
    // Z=1: NZ false -> instruction ends at the conditional step
    data_bus_in = 8'hC2; flag_z = 1'b1;
    tick();
    exp_o = {3'd2, 4'd0, 8'hC2, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL jpnz_z1_s0: got %h want %h", obs, exp_o); end
    tick();
    exp_o = {3'd2, 4'd1, 8'hC2, 1'b0, 1'b1}; exp_w = mk_word(1'b0, 8'hC2, 4'd1, 2'b10);
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL jpnz_z1_end: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL jpnz_cond_word: got %h want %h", control_signals, exp_w); end
    tick();
    exp_o = {3'd0, 4'd0, 8'hC2, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL jpnz_z1_fetch: got %h want %h", obs, exp_o); end
    // Z=0: NZ true -> runs all four steps
    flag_z = 1'b0;
    taken[0] = {3'd2, 4'd0, 8'hC2, 1'b0, 1'b0};
    taken[1] = {3'd2, 4'd1, 8'hC2, 1'b0, 1'b0};
    taken[2] = {3'd2, 4'd2, 8'hC2, 1'b0, 1'b0};
    taken[3] = {3'd2, 4'd3, 8'hC2, 1'b0, 1'b1};
    taken[4] = {3'd0, 4'd0, 8'hC2, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (obs !== taken[i]) begin miscompares++; $display("FAIL jpnz_z0_c%0d: got %h want %h", i, obs, taken[i]); end
    end
  endtask

  task automatic test_cb_prefix();
    data_bus_in = 8'hCB;
    tick();
    exp_o = {3'd2, 4'd0, 8'hCB, 1'b0, 1'b0}; exp_w = mk_word(1'b0, 8'hCB, 4'd0, 2'b11);
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cb_prefix_exec: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL cb_prefix_word: got %h want %h", control_signals, exp_w); end
    data_bus_in = 8'h37;
    tick();
    exp_o = {3'd1, 4'd0, 8'hCB, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cb_fetch_state: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== FETCH_W) begin miscompares++; $display("FAIL cb_fetch_word: got %h want %h", control_signals, FETCH_W); end
    tick();
    exp_o = {3'd2, 4'd0, 8'h37, 1'b1, 1'b0}; exp_w = mk_word(1'b1, 8'h37, 4'd0, 2'b00);
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cb37_s0: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL cb37_s0_word: got %h want %h", control_signals, exp_w); end
    tick();
    exp_o = {3'd2, 4'd1, 8'h37, 1'b1, 1'b1}; exp_w = mk_word(1'b1, 8'h37, 4'd1, 2'b01);
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cb37_s1: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL cb37_s1_word: got %h want %h", control_signals, exp_w); end
    data_bus_in = 8'h00;
    tick();
    exp_o = {3'd0, 4'd0, 8'h37, 1'b1, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cb_back_fetch: got %h want %h", obs, exp_o); end
    tick();
    exp_o = {3'd2, 4'd0, 8'h00, 1'b0, 1'b1};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cb_cleared: got %h want %h", obs, exp_o); end
    tick();
  endtask

  task automatic test_cb_double();
    data_bus_in = 8'hCB;
    tick(); tick(); tick();
    exp_o = {3'd2, 4'd0, 8'hCB, 1'b1, 1'b1}; exp_w = mk_word(1'b1, 8'hCB, 4'd0, 2'b11);
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cbcb_end: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL cbcb_word: got %h want %h", control_signals, exp_w); end
    tick();
    exp_o = {3'd0, 4'd0, 8'hCB, 1'b1, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL cbcb_fetch: got %h want %h", obs, exp_o); end
  endtask

  task automatic test_halt();
    data_bus_in = 8'h76;
    tick();
    exp_o = {3'd2, 4'd0, 8'h76, 1'b0, 1'b1};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL halt_exec: got %h want %h", obs, exp_o); end
    tick();
    exp_o = {3'd3, 4'd0, 8'h76, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL halt_enter: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== IDLE_W) begin miscompares++; $display("FAIL halt_word: got %h want %h", control_signals, IDLE_W); end
    tick();
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL halt_stay: got %h want %h", obs, exp_o); end
    irq_pending = 1'b1; stall = 1'b1;
    tick();
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL halt_stalled_irq: got %h want %h", obs, exp_o); end
    stall = 1'b0;
    tick();
    exp_o = {3'd0, 4'd0, 8'h76, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL halt_wake: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== FETCH_W) begin miscompares++; $display("FAIL halt_wake_word: got %h want %h", control_signals, FETCH_W); end
    irq_pending = 1'b0;
  endtask

  task automatic test_stall();
    data_bus_in = 8'h01;
    tick(); tick();
    exp_o = {3'd2, 4'd1, 8'h01, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stall_pre: got %h want %h", obs, exp_o); end
    stall = 1'b1;
    #1;
    vectors++; if (control_signals !== IDLE_W) begin miscompares++; $display("FAIL stall_word: got %h want %h", control_signals, IDLE_W); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_o); end
    end
    stall = 1'b0;
    #1;
    exp_w = mk_word(1'b0, 8'h01, 4'd1, 2'b00);
    vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL stall_resume_word: got %h want %h", control_signals, exp_w); end
    tick(); tick();
    // Stall on the final step suppresses inst_done until released
    stall = 1'b1;
    #1;
    exp_o = {3'd2, 4'd3, 8'h01, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stall_last_step: got %h want %h", obs, exp_o); end
    tick();
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stall_last_hold: got %h want %h", obs, exp_o); end
    stall = 1'b0;
    #1;
    exp_o = {3'd2, 4'd3, 8'h01, 1'b0, 1'b1};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stall_last_done: got %h want %h", obs, exp_o); end
    tick();
    exp_o = {3'd0, 4'd0, 8'h01, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL stall_refetch: got %h want %h", obs, exp_o); end
  endtask

  task automatic test_overflow();
    irq_pending = 1'b1;
    data_bus_in = 8'hD3;
    tick();
    for (int s = 0; s < 16; s++) begin
      exp_o = {3'd2, 4'(s), 8'hD3, 1'b0, (s == 15)};
      exp_w = mk_word(1'b0, 8'hD3, 4'(s), 2'b00);
      vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL ovf_step%0d: got %h want %h", s, obs, exp_o); end
      vectors++; if (control_signals !== exp_w) begin miscompares++; $display("FAIL ovf_word%0d: got %h want %h", s, control_signals, exp_w); end
      tick();
    end
    exp_o = {3'd0, 4'd0, 8'hD3, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL ovf_end: got %h want %h", obs, exp_o); end
    irq_pending = 1'b0;
  endtask

  task automatic test_async_reset();
    data_bus_in = 8'hD3;
    tick(); tick(); tick(); tick(); tick();
    exp_o = {3'd2, 4'd4, 8'hD3, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL arst_pre: got %h want %h", obs, exp_o); end
    #2 rst = 1'b1;
    #1;
    exp_o = {3'd0, 4'd0, 8'h00, 1'b0, 1'b0};
    vectors++; if (obs !== exp_o) begin miscompares++; $display("FAIL arst_regs: got %h want %h", obs, exp_o); end
    vectors++; if (control_signals !== IDLE_W) begin miscompares++; $display("FAIL arst_word: got %h want %h", control_signals, IDLE_W); end
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (control_signals !== FETCH_W) begin miscompares++; $display("FAIL arst_release: got %h want %h", control_signals, FETCH_W); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_jp_nz();
    test_cb_prefix();
    test_cb_double();
    test_halt();
    test_stall();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
